seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of hex digits (1..16).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1; 1 inverts all segment and anode outputs.
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clock cycles per digit slot in scan mode (>=2).
REQ-004 SHALL have parameter BLINK_HALF, default 25_000_000, clock cycles per blink half-period (>=2).
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 load_valid_i  in  1  new display word offered.
REQ-008 load_ready_o  out  1  pending buffer empty; word accepted when valid&ready at an edge.
REQ-009 load_data_i  in  4*NUM_DIGITS  nibble k = digit k (digit 0 = rightmost).
REQ-010 load_dp_i  in  NUM_DIGITS  decimal point per digit.
REQ-011 blank_lz_i  in  1  leading-zero blanking enable (live, not latched).
REQ-012 blink_mask_i  in  NUM_DIGITS  digits blanked during blink-off phase (live).
REQ-013 scan_en_i  in  1  1 = multiplexed scan mode, 0 = static mode.
REQ-014 segs_o  out  [NUM_DIGITS][8]  static per-digit segment bytes.
REQ-015 scan_seg_o  out  8  segment byte of currently scanned digit.
REQ-016 scan_an_o  out  NUM_DIGITS  one-hot digit enable.

Function
REQ-017 Raw byte bit7..bit1 = segments a..g, bit0 = dp; hex codes 0..F = FC,60,DA,F2,66,B6,BE,E0,FE,F6,EE,3E,9C,7A,9E,8E, OR'd with dp into bit0; blank = 00; output = ~raw when ACTIVE_LOW else raw.
REQ-018 Two-stage buffering: pending register (data, dp, pending_valid) and active register (data, dp, shown flag); load_ready_o = !pending_valid.
REQ-019 Commit (pending -> active, shown:=1, pending_valid:=0) at any edge with pending_valid=1 when scan_en_i=0, or when scan_en_i=1 and a scan tick wraps index NUM_DIGITS-1 -> 0.
REQ-020 Commit and accept at same edge: old pending goes to active, new word into pending, pending_valid stays 1.
REQ-021 Static latency: accept at edge N, commit at edge N+1, segs_o updated at edge N+2; load_ready_o low only during cycle N..N+1.
REQ-022 While shown=0 every digit is blank.
REQ-023 Leading-zero blanking: digit k>0 blank when blank_lz_i=1 and nibbles k..NUM_DIGITS-1 all zero and dp k..NUM_DIGITS-1 all zero; digit 0 never LZ-blanked.
REQ-024 Blink phase register toggles every BLINK_HALF cycles (free-running counter); phase=1 blanks digits with blink_mask_i set.
REQ-025 Blanked digit outputs raw 00 including dp.
REQ-026 segs_o registered from active state every cycle regardless of scan_en_i.
REQ-027 Scan: divider counts 0..SCAN_DIV-1, tick at SCAN_DIV-1; index 0..NUM_DIGITS-1 increments on tick, wraps to 0.
REQ-028 scan_an_o registered, raw one-hot bit[index]; scan_seg_o registered byte of digit[index]; both change one cycle after index.
REQ-029 scan_en_i=0: divider and index held at 0, scan_an_o raw all-zero, scan_seg_o raw 00.
REQ-030 scan_en_i 0->1: first tick after SCAN_DIV cycles; digit 0 displayed from the cycle after enable.
REQ-031 NUM_DIGITS=1: every tick is a wrap (commit point).

Reset
REQ-032 rst_ni low SHALL immediately clear pending_valid, shown, data, dp, divider, index, blink counter and phase.
REQ-033 During/after reset: load_ready_o=1, segs_o all raw 00, scan_an_o raw 0, scan_seg_o raw 00 (ACTIVE_LOW: FF/all-ones).
REQ-034 Reset mid-commit or mid-scan SHALL discard pending word; no partial frame after release.

Verification
REQ-035 Static, ACTIVE_LOW=1, NUM_DIGITS=8: load 0x0123ABCD, dp=0 -> two cycles after accept segs_o[0..7] = ~7A,~9C,~3E,~EE,~F2,~DA,~60,~FC.
REQ-036 blank_lz_i=1, load 0x00000050 dp=0 -> digits 2..7 = FF, digit1 = ~B6, digit0 = ~FC; with dp[5]=1 digit5 = ~FD, digits 2..4 = ~FC.
REQ-037 Scan, SCAN_DIV=4, NUM_DIGITS=4: load mid-frame -> old value scanned until index wraps, new value from digit 0 of next frame; scan_an_o steps 0001,0010,0100,1000 (raw) every 4 cycles.
REQ-038 Hold load_valid_i=1 with back-to-back words in scan mode -> load_ready_o low until wrap; second word never overwrites pending; each word committed once in order.
REQ-039 BLINK_HALF=8, blink_mask=0x01 -> digit0 alternates code/blank every 8 cycles, others steady.
REQ-040 Assert rst_ni low mid-scan with pending word -> outputs blank same cycle; after release load_ready_o=1, no stale digits shown.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// Hex 7-segment display controller: double-buffered display word, leading-zero
// blanking, blink, and either static per-digit outputs or a multiplexed scan.
module seg_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         load_valid_i,
  output logic                         load_ready_o,
  input  logic [4*NUM_DIGITS-1:0]      load_data_i,
  input  logic [NUM_DIGITS-1:0]        load_dp_i,
  input  logic                         blank_lz_i,
  input  logic [NUM_DIGITS-1:0]        blink_mask_i,
  input  logic                         scan_en_i,
  output logic [NUM_DIGITS-1:0][7:0]   segs_o,
  output logic [7:0]                   scan_seg_o,
  output logic [NUM_DIGITS-1:0]        scan_an_o
);

  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   DIV_W = $clog2(SCAN_DIV);
  localparam int   BLK_W = $clog2(BLINK_HALF);
  localparam logic POL   = (ACTIVE_LOW != 0);

  function automatic logic [7:0] hex_code(input logic [3:0] nib);
    case (nib)
      4'h0: hex_code = 8'hFC;  4'h1: hex_code = 8'h60;
      4'h2: hex_code = 8'hDA;  4'h3: hex_code = 8'hF2;
      4'h4: hex_code = 8'h66;  4'h5: hex_code = 8'hB6;
      4'h6: hex_code = 8'hBE;  4'h7: hex_code = 8'hE0;
      4'h8: hex_code = 8'hFE;  4'h9: hex_code = 8'hF6;
      4'hA: hex_code = 8'hEE;  4'hB: hex_code = 8'h3E;
      4'hC: hex_code = 8'h9C;  4'hD: hex_code = 8'h7A;
      4'hE: hex_code = 8'h9E;  default: hex_code = 8'h8E;
    endcase
  endfunction

  logic                        pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0]     pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]       pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                        shown_q, shown_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [BLK_W-1:0]            blk_cnt_q, blk_cnt_d;
  logic                        phase_q, phase_d;
  logic [NUM_DIGITS-1:0][7:0]  segs_q, segs_d;
  logic [NUM_DIGITS-1:0]       scan_an_q, scan_an_d;
  logic [7:0]                  scan_seg_q, scan_seg_d;

  logic                        tick, wrap, commit, accept;
  logic [NUM_DIGITS:0]         zero_above;
  logic [NUM_DIGITS-1:0][7:0]  digit_raw;

  assign tick   = scan_en_i && (div_q == DIV_W'(SCAN_DIV - 1));
  assign wrap   = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign commit = pend_valid_q && (!scan_en_i || wrap);
  assign accept = load_valid_i && !pend_valid_q;

  // zero_above[k]: digits k..NUM_DIGITS-1 carry neither a nonzero nibble nor a dp
  always_comb begin
    zero_above             = '0;
    zero_above[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above[k] = zero_above[k+1] && (act_data_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic lz_blank, blank;
    if (gi == 0) begin : g_lsd
      assign lz_blank = 1'b0;
    end else begin : g_upper
      assign lz_blank = blank_lz_i && zero_above[gi];
    end
    assign blank = !shown_q || lz_blank || (phase_q && blink_mask_i[gi]);
    assign digit_raw[gi] = blank ? 8'h00
                                 : (hex_code(act_data_q[4*gi +: 4]) | {7'b0, act_dp_q[gi]});
    assign segs_o[gi] = segs_q[gi] ^ {8{POL}};
  end

  always_comb begin
    pend_valid_d = (pend_valid_q && !commit) || accept;
    pend_data_d  = accept ? load_data_i : pend_data_q;
    pend_dp_d    = accept ? load_dp_i   : pend_dp_q;
    act_data_d   = commit ? pend_data_q : act_data_q;
    act_dp_d     = commit ? pend_dp_q   : act_dp_q;
    shown_d      = shown_q || commit;

    div_d        = '0;
    idx_d        = '0;
    scan_an_d    = '0;
    scan_seg_d   = 8'h00;
    if (scan_en_i) begin
      div_d = tick ? '0 : div_q + 1'b1;
      idx_d = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
      scan_an_d[idx_q] = 1'b1;
      scan_seg_d       = digit_raw[idx_q];
    end

    if (blk_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
      blk_cnt_d = '0;
      phase_d   = !phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + 1'b1;
      phase_d   = phase_q;
    end

    segs_d = digit_raw;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      shown_q      <= 1'b0;
      div_q        <= '0;
      idx_q        <= '0;
      blk_cnt_q    <= '0;
      phase_q      <= 1'b0;
      segs_q       <= '0;
      scan_an_q    <= '0;
      scan_seg_q   <= 8'h00;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      shown_q      <= shown_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      blk_cnt_q    <= blk_cnt_d;
      phase_q      <= phase_d;
      segs_q       <= segs_d;
      scan_an_q    <= scan_an_d;
      scan_seg_q   <= scan_seg_d;
    end
  end

  assign load_ready_o = !pend_valid_q;
  assign scan_an_o    = scan_an_q ^ {NUM_DIGITS{POL}};
  assign scan_seg_o   = scan_seg_q ^ {8{POL}};

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl (4 digits, active-low): random and directed stimulus
// checked every cycle against an edge-counting reference model of the display.
module tb_seg_display_ctrl;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [4*N-1:0]   load_data = '0;
  logic [N-1:0]     load_dp = '0;
  logic             blank_lz = 1'b0;
  logic [N-1:0]     blink_mask = '0;
  logic             scan_en = 1'b0;
  logic [N-1:0][7:0] segs;
  logic [7:0]       scan_seg;
  logic [N-1:0]     scan_an;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state: pending/active words and edge counts since reset/enable
  bit          m_pv, m_shown;
  logic [15:0] m_pdata, m_adata;
  logic [3:0]  m_pdp, m_adp;
  int          m_ncyc, m_en;
  logic [7:0]  codes [16];

  seg_display_ctrl #(
    .NUM_DIGITS(N), .ACTIVE_LOW(1), .SCAN_DIV(SD), .BLINK_HALF(BH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .load_valid_i(load_valid), .load_ready_o(load_ready),
    .load_data_i(load_data), .load_dp_i(load_dp),
    .blank_lz_i(blank_lz), .blink_mask_i(blink_mask), .scan_en_i(scan_en),
    .segs_o(segs), .scan_seg_o(scan_seg), .scan_an_o(scan_an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [7:0] dig(input int k, input logic [15:0] d, input logic [3:0] p,
                                     input bit sh, input logic lz, input logic [3:0] msk,
                                     input bit ph);
    logic [15:0] dd;
    logic [3:0]  pp;
    if (!sh) return 8'h00;
    dd = d >> (4 * k);
    pp = p >> k;
    if (k > 0 && lz && dd == 16'h0 && pp == 4'h0) return 8'h00;
    if (ph && msk[k]) return 8'h00;
    return codes[dd[3:0]] | {7'b0, pp[0]};
  endfunction

  task automatic model_reset();
    m_pv = 0; m_shown = 0; m_pdata = '0; m_adata = '0;
    m_pdp = '0; m_adp = '0; m_ncyc = 0; m_en = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {31'b0, load_ready}, 32'h1);
    chk({tag, "_segs"}, segs, 32'hFFFF_FFFF);
    chk({tag, "_an"}, {28'b0, scan_an}, 32'hF);
    chk({tag, "_sseg"}, {24'b0, scan_seg}, 32'hFF);
  endtask

  // one clock edge: predict post-edge outputs from pre-edge model state and inputs
  task automatic step();
    logic [7:0]  raw [N];
    logic [31:0] e_segs;
    logic [3:0]  e_an;
    logic [7:0]  e_sseg;
    bit ph, commit, accept;
    int idx, en_after;
    ph = ((m_ncyc / BH) % 2) == 1;
    for (int k = 0; k < N; k++) begin
      raw[k] = dig(k, m_adata, m_adp, m_shown, blank_lz, blink_mask, ph);
      e_segs[8*k +: 8] = ~raw[k];
    end
    idx = (m_en / SD) % N;
    if (scan_en) begin
      e_an = ~(4'b0001 << idx);
      e_sseg = ~raw[idx];
      en_after = m_en + 1;
    end else begin
      e_an = 4'hF;
      e_sseg = 8'hFF;
      en_after = 0;
    end
    commit = m_pv && (!scan_en || (en_after % (SD * N) == 0));
    accept = load_valid && !m_pv;
    if (commit) begin
      m_adata = m_pdata; m_adp = m_pdp; m_shown = 1;
    end
    m_pv = (m_pv && !commit) || accept;
    if (accept) begin
      m_pdata = load_data; m_pdp = load_dp;
    end
    m_en = en_after;
    m_ncyc++;
    @(posedge clk);
    #1;
    chk("load_ready", {31'b0, load_ready}, {31'b0, !m_pv});
    chk("segs", segs, e_segs);
    chk("scan_an", {28'b0, scan_an}, {28'b0, e_an});
    chk("scan_seg", {24'b0, scan_seg}, {24'b0, e_sseg});
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p);
    load_data = d; load_dp = p; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    codes = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) step();

    // leading-zero blanking and decimal points, then a plain hex word
    blank_lz = 1'b1;
    load_word(16'h0050, 4'b0000);
    chk("lz_0050", segs, 32'hFFFF_4903);
    load_word(16'h0050, 4'b1000);
    chk("lz_dp3", segs, 32'h0203_4903);
    blank_lz = 1'b0;
    load_word(16'hABCD, 4'b0000);
    chk("hex_abcd", segs, 32'h11C1_6385);

    // random static traffic with live blanking controls
    repeat (150) begin
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 16'($urandom) >> $urandom_range(0, 15);
      load_dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      blank_lz   = 1'($urandom_range(0, 1));
      blink_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      step();
    end

    // blink on digit 0 with a steady word
    load_valid = 1'b0; blank_lz = 1'b0; blink_mask = '0;
    load_word(16'h1234, 4'b0000);
    blink_mask = 4'b0001;
    repeat (34) step();
    blink_mask = '0;

    // scan mode: sparse loads landing mid-frame
    scan_en = 1'b1;
    repeat (200) begin
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = 16'($urandom);
      load_dp    = 4'($urandom);
      step();
    end

    // back-to-back offers held valid in scan mode
    repeat (100) begin
      load_valid = 1'b1;
      load_data  = 16'($urandom) >> $urandom_range(0, 12);
      load_dp    = '0;
      blank_lz   = 1'b1;
      step();
    end
    load_valid = 1'b0;

    // scan disable and re-enable
    scan_en = 1'b0;
    repeat (10) step();
    scan_en = 1'b1;
    repeat (40) step();

    // reset while a word is pending mid-scan
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    load_dp    = 4'b0101;
    for (int i = 0; i < 40 && !m_pv; i++) step();
    load_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk_idle("rst_release");
    repeat (40) step();
    load_word(16'h0007, 4'b0000);
    repeat (40) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
